// File: rtl/poly_synth_pkg.sv
// Shared types and constants for the polyphonic synthesiser: waveform modes,
// FSM states and the per-voice phase tuning words.
package poly_synth_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARE = 2'd0,
        MODE_SAW    = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SINE   = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_STEP,
        ST_MIX,
        ST_OUT
    } state_e;

    // Equal-tempered semitone steps from 1024 (ratio 2^(1/12) ~ 1.0595), rounded.
    localparam int TUNE_N = 12;
    localparam logic [15:0] TUNE [TUNE_N] = '{
        16'd1024, 16'd1085, 16'd1149, 16'd1218, 16'd1290, 16'd1367,
        16'd1448, 16'd1534, 16'd1625, 16'd1722, 16'd1825, 16'd1933
    };

endpackage

// File: rtl/poly_synth_if.sv
// Key/mode inputs and mixed-sample outputs of poly_synth bundled as one port.
interface poly_synth_if #(
    parameter int N_KEYS = 8,
    parameter int W      = 8
);
    localparam int CNT_W = $clog2(N_KEYS + 1);

    logic [N_KEYS-1:0] keys;
    logic [1:0]        mode;
    logic [W-1:0]      wave;
    logic              wave_valid;
    logic [CNT_W-1:0]  active_count;
    logic              overrun;

    modport master (
        output keys, mode,
        input  wave, wave_valid, active_count, overrun
    );

    modport slave (
        input  keys, mode,
        output wave, wave_valid, active_count, overrun
    );

endinterface

// File: rtl/poly_synth_wave_rom.sv
// 64-entry quarter-wave-symmetric sine table, combinational, offset binary,
// rescaled from its native 8-bit amplitude to W bits.
module wave_rom #(
    parameter int W = 8
) (
    input  logic [5:0]   addr_i,
    output logic [W-1:0] data_o
);

    localparam logic [7:0] SINE8 [64] = '{
        8'd128, 8'd140, 8'd153, 8'd165, 8'd177, 8'd188, 8'd199, 8'd209,
        8'd218, 8'd226, 8'd234, 8'd240, 8'd245, 8'd250, 8'd253, 8'd254,
        8'd255, 8'd254, 8'd253, 8'd250, 8'd245, 8'd240, 8'd234, 8'd226,
        8'd218, 8'd209, 8'd199, 8'd188, 8'd177, 8'd165, 8'd153, 8'd140,
        8'd128, 8'd116, 8'd103, 8'd91,  8'd79,  8'd68,  8'd57,  8'd47,
        8'd38,  8'd30,  8'd22,  8'd16,  8'd11,  8'd6,   8'd3,   8'd2,
        8'd1,   8'd2,   8'd3,   8'd6,   8'd11,  8'd16,  8'd22,  8'd30,
        8'd38,  8'd47,  8'd57,  8'd68,  8'd79,  8'd91,  8'd103, 8'd116
    };

    generate
        if (W >= 8) begin : g_widen
            assign data_o = W'(SINE8[addr_i]) << (W - 8);
        end else begin : g_narrow
            assign data_o = W'(SINE8[addr_i] >> (8 - W));
        end
    endgenerate

endmodule

// File: rtl/poly_synth.sv
// Polyphonic synthesiser: per-sample FSM latches keys, steps each voice's phase,
// mixes voices one per cycle into a signed sum and emits a saturated sample.
module poly_synth
    import poly_synth_pkg::*;
#(
    parameter int N_KEYS     = 8,
    parameter int W          = 8,
    parameter int ACC_W      = 16,
    parameter int SAMPLE_DIV = 16
) (
    input  logic         clk,
    input  logic         rst,
    poly_synth_if.slave  bus
);

    localparam int CNT_W = $clog2(N_KEYS + 1);
    localparam int IDX_W = (N_KEYS > 1) ? $clog2(N_KEYS) : 1;
    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int SUM_W = W + $clog2(N_KEYS) + 1;

    localparam logic [W-1:0]            MID_W  = W'(1) << (W - 1);
    localparam logic signed [SUM_W-1:0] MID_S  = SUM_W'(1) << (W - 1);
    localparam logic signed [SUM_W-1:0] SAT_HI = MID_S - SUM_W'(1);
    localparam logic signed [SUM_W-1:0] SAT_LO = ~SAT_HI;

    if (SAMPLE_DIV < N_KEYS + 4) begin : g_bad_div
        $error("poly_synth: SAMPLE_DIV must be at least N_KEYS+4");
    end

    logic [DIV_W-1:0] div_q;
    logic             div_wrap;
    logic             tick;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [SUM_W-1:0] acc_q, acc_d;
    logic [N_KEYS-1:0]       keys_q, keys_d;
    mode_e                   mode_q, mode_d;
    logic [CNT_W-1:0]        active_q, active_d;
    logic [W-1:0]            wave_q, wave_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;

    logic [ACC_W-1:0] phase_q [N_KEYS];
    logic [ACC_W-1:0] phase_d [N_KEYS];

    logic [CNT_W-1:0]        latch_cnt;
    logic [W-1:0]            voice_p;
    logic [W-1:0]            voice_p_shl;
    logic [W-1:0]            rom_data;
    logic [W-1:0]            sample;
    logic signed [SUM_W-1:0] contrib;
    logic signed [SUM_W-1:0] acc_sum;

    // tick is kept as its own net so the sample strobe can be observed on its own.
    assign div_wrap = (div_q == DIV_W'(SAMPLE_DIV - 1));
    assign tick     = div_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else if (div_wrap) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DIV_W'(1);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_KEYS; gi++) begin : g_voice
            localparam logic [ACC_W-1:0] TUNE_W = ACC_W'(TUNE[gi]);
            assign phase_d[gi] = (state_q != ST_STEP) ? phase_q[gi] :
                                 (keys_q[gi] ? phase_q[gi] + TUNE_W : '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= '{default: '0};
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        latch_cnt = '0;
        for (int k = 0; k < N_KEYS; k++) begin
            latch_cnt = latch_cnt + CNT_W'(bus.keys[k]);
        end
    end

    // Voice currently being mixed: its waveform sample from the top phase bits.
    assign voice_p     = phase_q[idx_q][ACC_W-1 -: W];
    assign voice_p_shl = {voice_p[W-2:0], 1'b0};

    wave_rom #(.W(W)) u_wave_rom (
        .addr_i (phase_q[idx_q][ACC_W-1 -: 6]),
        .data_o (rom_data)
    );

    always_comb begin
        sample = '0;
        case (mode_q)
            MODE_SQUARE: sample = voice_p[W-1] ? '1 : '0;
            MODE_SAW:    sample = voice_p;
            MODE_TRI:    sample = voice_p[W-1] ? ~voice_p_shl : voice_p_shl;
            MODE_SINE:   sample = rom_data;
            default:     sample = '0;
        endcase
    end

    assign contrib = keys_q[idx_q] ? ($signed(SUM_W'(sample)) - MID_S) : '0;
    assign acc_sum = acc_q + contrib;

    function automatic logic [W-1:0] to_offset(input logic signed [SUM_W-1:0] a);
        logic signed [SUM_W-1:0] s;
        if (a > SAT_HI) begin
            s = SAT_HI;
        end else if (a < SAT_LO) begin
            s = SAT_LO;
        end else begin
            s = a;
        end
        return W'(s) ^ MID_W;
    endfunction

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        keys_d    = keys_q;
        mode_d    = mode_q;
        active_d  = active_q;
        wave_d    = wave_q;
        valid_d   = 1'b0;
        overrun_d = overrun_q | (tick && (state_q != ST_IDLE));
        case (state_q)
            ST_IDLE: begin
                if (tick) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                keys_d   = bus.keys;
                mode_d   = mode_e'(bus.mode);
                active_d = latch_cnt;
                state_d  = ST_STEP;
            end
            ST_STEP: begin
                idx_d   = '0;
                acc_d   = '0;
                state_d = ST_MIX;
            end
            ST_MIX: begin
                acc_d = acc_sum;
                idx_d = idx_q + IDX_W'(1);
                // The final voice's sum is registered straight into wave so it is
                // visible together with wave_valid during OUT.
                if (idx_q == IDX_W'(N_KEYS - 1)) begin
                    wave_d  = to_offset(acc_sum);
                    valid_d = 1'b1;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            keys_q    <= '0;
            mode_q    <= MODE_SQUARE;
            active_q  <= '0;
            wave_q    <= MID_W;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            keys_q    <= keys_d;
            mode_q    <= mode_d;
            active_q  <= active_d;
            wave_q    <= wave_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.wave         = wave_q;
    assign bus.wave_valid   = valid_q;
    assign bus.active_count = active_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: doc/poly_synth.md
POLY_SYNTH -- requirements
Module: poly_synth

Interface
REQ-001 Parameter N_KEYS, default 8: number of key inputs and voices.
REQ-002 Parameter W, default 8: sample width, unsigned offset-binary at the output.
REQ-003 Parameter ACC_W, default 16: per-voice phase accumulator width.
REQ-004 Parameter SAMPLE_DIV, default 16: clk cycles per output sample, legal only if SAMPLE_DIV >= N_KEYS+4.
REQ-005 clk  in  1  sole clock, all logic on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 keys  in  N_KEYS  key k pressed when keys[k]=1; no synchroniser required.
REQ-008 mode  in  2  waveform select: 0 square, 1 saw, 2 triangle, 3 sine.
REQ-009 wave  out  W  mixed sample, registered.
REQ-010 wave_valid  out  1  one-cycle pulse when wave updates.
REQ-011 active_count  out  clog2(N_KEYS+1)  number of keys latched for the current sample.
REQ-012 overrun  out  1  sticky flag, set when a sample tick arrives while the FSM is not in IDLE.

Function
REQ-013 Divider counts 0..SAMPLE_DIV-1 and wraps; tick asserts on count SAMPLE_DIV-1.
REQ-014 FSM states: IDLE, LATCH, STEP, MIX, OUT.
REQ-015 IDLE -> LATCH on tick; a tick outside IDLE is ignored and sets overrun.
REQ-016 LATCH: register keys and mode; compute active_count. This is the only point where keys and mode are sampled.
REQ-017 STEP: phase[k] += TUNE[k] modulo 2^ACC_W for each latched key; each unlatched phase[k] clears to 0.
REQ-018 MIX: one voice per cycle for exactly N_KEYS cycles, index 0 upward.
REQ-019 MIX, latched voice: add (voice sample - 2^(W-1)) into a signed accumulator of W+clog2(N_KEYS)+1 bits. Unlatched voices add 0.
REQ-020 Voice sample p is derived from the top W bits of the phase, P:
- square: 2^W-1 if P MSB=1, else 0
- saw: P
- triangle: P<<1 when MSB=0, else ~(P<<1)
- sine: wave_rom indexed by the top 6 phase bits, output scaled to W bits
REQ-021 OUT: wave = clamp(acc, -2^(W-1), 2^(W-1)-1) + 2^(W-1); pulse wave_valid; return to IDLE.
REQ-022 Latency: wave_valid asserts exactly N_KEYS+3 cycles after the tick cycle.
REQ-023 No key latched: wave = 2^(W-1) (midscale), wave_valid still pulses.
REQ-024 A mode or keys change between LATCH and OUT does not affect the sample in flight.
REQ-025 Phase wraps silently. A key held across samples keeps phase continuity. Release followed by re-press restarts from phase 0.

Reset
REQ-026 rst forces the following, taking precedence over every other event in the same cycle:
- FSM to IDLE; divider, phases and accumulator to 0
- wave = 2^(W-1); wave_valid = 0; active_count = 0; overrun = 0
REQ-027 rst asserted mid-MIX discards the sample in flight; the first valid sample after release follows the first tick.

Structure
REQ-028 Shared package poly_synth_pkg holds:
- mode enumeration
- FSM state type
- TUNE table: ACC_W-bit tuning words, N_KEYS entries, TUNE[0]=1024 and each next entry ~x1.0595
REQ-029 Sine table lives in sub-module wave_rom: 64 entries, combinational, W-bit unsigned output. Mixer and FSM stay in poly_synth.

Verification
REQ-030 Bench uses default parameters.
REQ-031 Reset then idle: wave=128, one wave_valid every 16 cycles, each 11 cycles after its tick, overrun=0.
REQ-032 keys=8'h01, square: wave alternates 255 for 32 samples and 0 for 32 samples (period 64 samples); active_count=1.
REQ-033 keys=8'h03, square, both phases in the high half: acc=+254, wave saturates to 255. Both in the low half: wave=0.
REQ-034 keys=8'h01, saw: wave steps +4 per sample and wraps 252 -> 0.
REQ-035 Change mode from 0 to 1 during MIX: the current sample is still square, the next is saw. Release key 0 then re-press: the next sample restarts from phase-0 output.
REQ-036 Assert rst during MIX: no wave_valid from the aborted sample, wave=128. Force a tick while busy (bench override of the divider): overrun=1 until rst.
